// File: rtl/cic_comb_seq_if.sv
// Comb-section bus: decimated sample and strobe in; filtered sample, valid pulse and status out.
interface cic_comb_seq_if #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  data_in;
    logic             new_data;
    logic [OUT_W-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             primed;

    modport master (
        output data_in, new_data,
        input  data_out, data_valid, busy, overrun, primed
    );

    modport slave (
        input  data_in, new_data,
        output data_out, data_valid, busy, overrun, primed
    );
endinterface

// File: rtl/cic_comb_seq.sv
// CIC comb section: N_STAGES first differences on one shared subtractor, latency N_STAGES+1 cycles.
// A strobe that arrives while busy is dropped and flagged by overrun. COMB_ROUND_EN: round-half-up output.
module cic_comb_seq #(
    parameter int IN_W     = 27,
    parameter int OUT_W    = 16,
    parameter int N_STAGES = 3
) (
    input logic           clk,
    input logic           rst,
    cic_comb_seq_if.slave bus
);
    localparam int K_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int P_W = $clog2(N_STAGES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [IN_W-1:0] acc;
    logic [IN_W-1:0] d [N_STAGES];
    logic [K_W-1:0]  k;
    logic [P_W-1:0]  pcnt;
    logic [IN_W-1:0] diff;
    logic [OUT_W-1:0] outsel;

    // Modulo-2^IN_W difference: wrap is what cancels the integrator overflow.
    assign diff = acc - d[k];

`ifdef COMB_ROUND_EN
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (IN_W - OUT_W - 1);
    logic [IN_W:0] rnd;
    assign rnd    = {1'b0, diff} + HALF;
    assign outsel = rnd[IN_W] ? {OUT_W{1'b1}} : rnd[IN_W-1 -: OUT_W];
`else
    assign outsel = diff[IN_W-1 -: OUT_W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            k              <= '0;
            pcnt           <= '0;
            for (int i = 0; i < N_STAGES; i++) d[i] <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.primed     <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.new_data) begin
                        acc      <= bus.data_in;
                        k        <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    bus.overrun <= bus.new_data;
                    acc         <= diff;
                    d[k]        <= acc;
                    k           <= k + 1'b1;
                    if (k == K_W'(N_STAGES - 1)) begin
                        bus.data_out   <= outsel;
                        bus.data_valid <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                        if (pcnt != P_W'(N_STAGES)) pcnt <= pcnt + 1'b1;
                        if (pcnt >= P_W'(N_STAGES - 1)) bus.primed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
